// File: rtl/parc_core_commit_buffer_pkg.sv
// Shared core sizing for the reorder buffer and its commit/writeback path.
package parc_core_commit_buffer_pkg;

    localparam int unsigned CB_NSLOTS = 16;
    localparam int unsigned CB_XLEN   = 32;
    localparam int unsigned CB_REG_AW = 5;
    localparam int unsigned CB_CNT_W  = 32;

endpackage : parc_core_commit_buffer_pkg

// File: rtl/parc_core_commit_wbreg.sv
// Register-file writeback register stage: holds wen/waddr/wdata for one cycle.
module parc_core_commit_wbreg
    import parc_core_commit_buffer_pkg::*;
#(
    parameter int unsigned XLEN = CB_XLEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wen_d,
    input  logic [CB_REG_AW-1:0] waddr_d,
    input  logic [XLEN-1:0]      wdata_d,
    output logic                 wen,
    output logic [CB_REG_AW-1:0] waddr,
    output logic [XLEN-1:0]      wdata
);

    logic                 wen_q;
    logic [CB_REG_AW-1:0] waddr_q;
    logic [XLEN-1:0]      wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule : parc_core_commit_wbreg

// File: rtl/parc_core_commit_buffer.sv
// Commit buffer: per-slot result storage with filled tracking, retiring the ROB head
// into the register file one cycle after commit.
module parc_core_commit_buffer
    import parc_core_commit_buffer_pkg::*;
#(
    parameter int unsigned NSLOTS = CB_NSLOTS,
    parameter int unsigned XLEN   = CB_XLEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fill_val,
    input  logic [$clog2(NSLOTS)-1:0]  fill_slot,
    input  logic [XLEN-1:0]            fill_data,
    input  logic                       rob_commit_wen,
    input  logic [$clog2(NSLOTS)-1:0]  rob_commit_slot,
    input  logic [CB_REG_AW-1:0]       rob_commit_rf_waddr,
    input  logic                       squash_val,
    input  logic [$clog2(NSLOTS)-1:0]  squash_slot,
    output logic                       rf_wen,
    output logic [CB_REG_AW-1:0]       rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic [CB_CNT_W-1:0]        retire_count,
    output logic                       commit_err
);

    logic [XLEN-1:0]     data_q [NSLOTS];
    logic [NSLOTS-1:0]   filled_q, filled_d;
    logic [CB_CNT_W-1:0] retire_count_q, retire_count_d;
    logic                commit_err_q, commit_err_d;

    logic                 wb_wen_d;
    logic [CB_REG_AW-1:0] wb_waddr_d;
    logic [XLEN-1:0]      wb_wdata_d;
    logic                 fill_hits_commit;

    always_comb begin
        filled_d         = filled_q;
        retire_count_d   = retire_count_q;
        commit_err_d     = commit_err_q;
        wb_wen_d         = 1'b0;
        wb_waddr_d       = rf_waddr;
        wb_wdata_d       = rf_wdata;
        fill_hits_commit = fill_val && (fill_slot == rob_commit_slot);

        if (rob_commit_wen) begin
            wb_wen_d       = (rob_commit_rf_waddr != '0);
            wb_waddr_d     = rob_commit_rf_waddr;
            wb_wdata_d     = fill_hits_commit ? fill_data : data_q[rob_commit_slot];
            retire_count_d = retire_count_q + CB_CNT_W'(1);
            if (!filled_q[rob_commit_slot] && !fill_hits_commit) begin
                commit_err_d = 1'b1;
            end
        end

        // Later assignments take priority: squash beats fill, commit always clears.
        if (fill_val)       filled_d[fill_slot]       = 1'b1;
        if (rob_commit_wen) filled_d[rob_commit_slot] = 1'b0;
        if (squash_val)     filled_d[squash_slot]     = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filled_q       <= '0;
            retire_count_q <= '0;
            commit_err_q   <= 1'b0;
        end else begin
            filled_q       <= filled_d;
            retire_count_q <= retire_count_d;
            commit_err_q   <= commit_err_d;
        end
    end

    // Result storage is never reset; filled_q alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (fill_val && !reset) begin
            data_q[fill_slot] <= fill_data;
        end
    end

    parc_core_commit_wbreg #(
        .XLEN (XLEN)
    ) u_wbreg (
        .clk     (clk),
        .reset   (reset),
        .wen_d   (wb_wen_d),
        .waddr_d (wb_waddr_d),
        .wdata_d (wb_wdata_d),
        .wen     (rf_wen),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    assign retire_count = retire_count_q;
    assign commit_err   = commit_err_q;

endmodule : parc_core_commit_buffer

// File: tb/tb_parc_core_commit_buffer.sv
// Directed and randomized checks of parc_core_commit_buffer against a slot-level model.
module tb_parc_core_commit_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fill_val = 1'b0;
    logic [3:0]  fill_slot = '0;
    logic [31:0] fill_data = '0;
    logic        rob_commit_wen = 1'b0;
    logic [3:0]  rob_commit_slot = '0;
    logic [4:0]  rob_commit_rf_waddr = '0;
    logic        squash_val = 1'b0;
    logic [3:0]  squash_slot = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] retire_count;
    logic        commit_err;

    int tests = 0;
    int failed = 0;

    // Reference model state
    logic [31:0] m_data   [16];
    bit          m_known  [16];
    bit          m_filled [16];
    bit          e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    bit          e_wdata_known;
    logic [31:0] e_cnt;
    bit          e_err;

    parc_core_commit_buffer dut (
        .clk                 (clk),
        .reset               (reset),
        .fill_val            (fill_val),
        .fill_slot           (fill_slot),
        .fill_data           (fill_data),
        .rob_commit_wen      (rob_commit_wen),
        .rob_commit_slot     (rob_commit_slot),
        .rob_commit_rf_waddr (rob_commit_rf_waddr),
        .squash_val          (squash_val),
        .squash_slot         (squash_slot),
        .rf_wen              (rf_wen),
        .rf_waddr            (rf_waddr),
        .rf_wdata            (rf_wdata),
        .retire_count        (retire_count),
        .commit_err          (commit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_filled[i] = 0;
        e_wen = 0; e_waddr = '0; e_wdata = '0; e_wdata_known = 1;
        e_cnt = '0; e_err = 0;
    endtask

    task automatic model_step();
        bit byp;
        e_wen = 0;
        if (rob_commit_wen) begin
            byp = fill_val && (fill_slot == rob_commit_slot);
            e_waddr = rob_commit_rf_waddr;
            e_wen = (rob_commit_rf_waddr != 0);
            e_wdata = byp ? fill_data : m_data[rob_commit_slot];
            e_wdata_known = byp || m_known[rob_commit_slot];
            e_cnt = e_cnt + 1;
            if (!m_filled[rob_commit_slot] && !byp) e_err = 1;
        end
        if (fill_val) begin
            m_data[fill_slot] = fill_data;
            m_known[fill_slot] = 1;
            m_filled[fill_slot] = 1;
        end
        if (rob_commit_wen) m_filled[rob_commit_slot] = 0;
        if (squash_val) m_filled[squash_slot] = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rf_wen"}, 32'(rf_wen), 32'(e_wen));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(e_waddr));
        if (e_wdata_known) chk({tag, ".rf_wdata"}, rf_wdata, e_wdata);
        chk({tag, ".retire_count"}, retire_count, e_cnt);
        chk({tag, ".commit_err"}, 32'(commit_err), 32'(e_err));
    endtask

    task automatic step(input string tag,
                        input logic fv, input logic [3:0] fs, input logic [31:0] fd,
                        input logic cw, input logic [3:0] cs, input logic [4:0] wa,
                        input logic sv, input logic [3:0] ss);
        fill_val = fv; fill_slot = fs; fill_data = fd;
        rob_commit_wen = cw; rob_commit_slot = cs; rob_commit_rf_waddr = wa;
        squash_val = sv; squash_slot = ss;
        model_step();
        @(posedge clk); #1;
        check_all(tag);
        fill_val = 0; rob_commit_wen = 0; squash_val = 0;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        check_all("reset");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_data[i] = '0; m_known[i] = 0; m_filled[i] = 0;
        end
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        check_all("reset0");

        // Fill then commit a cycle later
        step("fill3", 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step("commit3", 0, 0, 0, 1, 3, 7, 0, 0);
        chk("d36.rf_wen", 32'(rf_wen), 32'd1);
        chk("d36.rf_waddr", 32'(rf_waddr), 32'd7);
        chk("d36.rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("d36.retire_count", retire_count, 32'd1);
        idle("idle36");
        chk("d36.wen_drop", 32'(rf_wen), 32'd0);

        // Same-cycle fill and commit bypass; re-commit proves filled was cleared
        step("byp5", 1, 5, 32'h12345678, 1, 5, 9, 0, 0);
        chk("d37.rf_wdata", rf_wdata, 32'h12345678);
        chk("d37.commit_err", 32'(commit_err), 32'd0);
        step("recommit5", 0, 0, 0, 1, 5, 9, 0, 0);
        chk("d37.filled_cleared", 32'(commit_err), 32'd1);
        do_reset();

        // Commit to r0 retires but does not write
        step("fill2", 1, 2, 32'hA5A5_0002, 0, 0, 0, 0, 0);
        step("commit2_r0", 0, 0, 0, 1, 2, 0, 0, 0);
        chk("d38.rf_wen", 32'(rf_wen), 32'd0);
        chk("d38.retire_count", retire_count, 32'd1);
        chk("d38.rf_wdata", rf_wdata, 32'hA5A5_0002);

        // Commit of unfilled slot sets a sticky error
        step("commit8", 0, 0, 0, 1, 8, 3, 0, 0);
        chk("d39.err_set", 32'(commit_err), 32'd1);
        chk("d39.rf_wen", 32'(rf_wen), 32'd1);
        for (int i = 0; i < 20; i++) idle("idle39");
        chk("d39.err_sticky", 32'(commit_err), 32'd1);
        do_reset();
        chk("d39.err_cleared", 32'(commit_err), 32'd0);

        // Squash wins over same-cycle fill
        step("fillsq4", 1, 4, 32'h0000_4444, 0, 0, 0, 1, 4);
        step("commit4", 0, 0, 0, 1, 4, 1, 0, 0);
        chk("d40.err", 32'(commit_err), 32'd1);
        do_reset();

        // Commit and squash on the same slot: commit proceeds
        step("fill6", 1, 6, 32'h6666_0006, 0, 0, 0, 0, 0);
        step("commitsq6", 0, 0, 0, 1, 6, 12, 1, 6);
        chk("d28.rf_wdata", rf_wdata, 32'h6666_0006);
        chk("d28.err", 32'(commit_err), 32'd0);

        // Retire counter wrap
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        e_cnt = 32'hFFFF_FFFF;
        #1;
        chk("d41.preset", retire_count, 32'hFFFF_FFFF);
        step("fill1", 1, 1, 32'h1111_1111, 0, 0, 0, 0, 0);
        step("commit_wrap", 0, 0, 0, 1, 1, 2, 0, 0);
        chk("d41.wrap", retire_count, 32'd0);

        // Reset asserted mid-commit clears outputs immediately and drops the commit
        step("fill7", 1, 7, 32'h7777_7777, 0, 0, 0, 0, 0);
        step("commit7", 0, 0, 0, 1, 7, 5, 0, 0);
        rob_commit_wen = 1; rob_commit_slot = 7; rob_commit_rf_waddr = 5;
        fill_val = 1; fill_slot = 9; fill_data = 32'h9999_9999;
        #2;
        reset = 1;
        #1;
        chk("d41.async_wen", 32'(rf_wen), 32'd0);
        chk("d41.async_waddr", 32'(rf_waddr), 32'd0);
        chk("d41.async_wdata", rf_wdata, 32'd0);
        chk("d41.async_cnt", retire_count, 32'd0);
        chk("d41.async_err", 32'(commit_err), 32'd0);
        @(posedge clk); #1;
        rob_commit_wen = 0; fill_val = 0;
        reset = 0;
        model_reset();
        check_all("after_reset");
        step("commit9", 0, 0, 0, 1, 9, 4, 0, 0);
        chk("d31.fill_discarded", 32'(commit_err), 32'd1);
        do_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 logic'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), $urandom,
                 logic'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)), 5'($urandom),
                 logic'($urandom_range(0, 4) == 0), 4'($urandom_range(0, 5)));
            if (n == 199) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_parc_core_commit_buffer

// File: doc/parc_core_commit_buffer.md
PARC_CORE_COMMIT_BUFFER -- requirements
Module: parc_core_commit_buffer

Interface
REQ-001 SHALL have parameter NSLOTS, default 16, meaning number of reorder-buffer slots; slot index width is log2(NSLOTS).
REQ-002 SHALL have parameter XLEN, default 32, meaning result data width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port fill_val, input, 1 bit: a result is written into a slot this cycle.
REQ-006 SHALL have port fill_slot, input, 4 bits: target ROB slot of the fill.
REQ-007 SHALL have port fill_data, input, XLEN bits: result value of the fill.
REQ-008 SHALL have port rob_commit_wen, input, 1 bit: the ROB head retires this cycle.
REQ-009 SHALL have port rob_commit_slot, input, 4 bits: slot being retired.
REQ-010 SHALL have port rob_commit_rf_waddr, input, 5 bits: architectural destination register of the retiring slot.
REQ-011 SHALL have port squash_val, input, 1 bit: invalidate a speculative slot.
REQ-012 SHALL have port squash_slot, input, 4 bits: slot to invalidate.
REQ-013 SHALL have port rf_wen, output, 1 bit: register-file write enable.
REQ-014 SHALL have port rf_waddr, output, 5 bits: register-file write address.
REQ-015 SHALL have port rf_wdata, output, XLEN bits: register-file write data.
REQ-016 SHALL have port retire_count, output, 32 bits: number of retired instructions.
REQ-017 SHALL have port commit_err, output, 1 bit: sticky flag set on commit of an unfilled slot.

Function
REQ-018 SHALL hold a per-slot data array (XLEN bits) and per-slot filled bit.
REQ-019 fill_val SHALL write fill_data to data[fill_slot] and set filled[fill_slot] at the next edge.
REQ-020 rob_commit_wen SHALL clear filled[rob_commit_slot] at the next edge.
REQ-021 Commit output SHALL be registered, with 1-cycle latency: rf_wen, rf_waddr and rf_wdata SHALL be valid in the cycle after rob_commit_wen.
REQ-022 rf_wdata SHALL equal data[rob_commit_slot]; when fill_val && fill_slot==rob_commit_slot in the same cycle, it SHALL equal fill_data (bypass), and filled SHALL end cleared.
REQ-023 rf_wen SHALL be 0 when rob_commit_rf_waddr==0; rf_waddr and rf_wdata SHALL still be updated.
REQ-024 rf_wen SHALL be 0 in any cycle not following a commit.
REQ-025 retire_count SHALL increment by 1 per commit, including commits to r0, and wrap modulo 2^32.
REQ-026 commit_err SHALL set when a commit targets a slot that is neither filled nor being filled that cycle; it SHALL clear only on reset, and rf_wen SHALL still follow REQ-023.
REQ-027 squash_val SHALL clear filled[squash_slot]; when squash and fill target the same slot in the same cycle, squash SHALL win.
REQ-028 When commit and squash target the same slot in the same cycle, the commit SHALL proceed and the squash SHALL be ignored for output purposes.
REQ-029 Data array contents SHALL NOT be cleared on commit or squash; only the filled bits change.

Reset
REQ-030 While reset is high, filled bits, rf_wen, rf_waddr, rf_wdata, retire_count and commit_err SHALL be 0, asynchronously.
REQ-031 A commit or fill coincident with reset assertion SHALL be discarded.
REQ-032 The data array SHALL NOT require reset.

Structure
REQ-033 NSLOTS, XLEN and the register-address width (5) SHALL be defined in a shared core package and also used by the reorder buffer.
REQ-034 The output register stage SHALL be one sub-module, parc_core_commit_wbreg, holding wen, waddr and wdata with asynchronous reset.
REQ-035 The data array SHALL be inferred as flip-flops with one write port and one asynchronous read port.

Verification
REQ-036 Fill slot 3 = 0xDEADBEEF, then next cycle commit slot 3 waddr 7 -> one cycle later rf_wen=1, rf_waddr=7, rf_wdata=0xDEADBEEF, retire_count=1.
REQ-037 Same-cycle fill slot 5 = 0x12345678 and commit slot 5 waddr 9 -> next cycle rf_wdata=0x12345678, commit_err=0, filled[5]=0.
REQ-038 Fill slot 2, commit slot 2 waddr 0 -> rf_wen=0, retire_count increments.
REQ-039 Commit of never-filled slot 8 -> commit_err=1 and stays 1 through 20 idle cycles until reset.
REQ-040 Fill and squash slot 4 in the same cycle, then commit slot 4 -> commit_err=1.
REQ-041 Preset retire_count to 0xFFFFFFFF via repeated commits (or force), then one commit -> 0; assert reset mid-commit -> all outputs 0 immediately.
